// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide.
// Optional macro MULDIV_EARLY_OUT_EN finishes divide-by-zero, signed overflow and zero multiplies in one cycle.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            reg_write_out
);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  state_t state, state_next;

  logic [CNT_W-1:0]  cnt;
  logic [2:0]        funct3_q;
  logic [XLEN-1:0]   a_q, b_mag;
  logic [2*XLEN-1:0] acc, acc_init, mul_next, div_next, prod;
  logic              neg_q, div_zero_q, done_q;

  logic              sign_a, sign_b, neg_in, early;
  logic [XLEN-1:0]   a_mag_in, b_mag_in, qr, fin;
  logic [XLEN:0]     mul_sum, rem_sh;
  logic [XLEN-1:0]   rem_new;
  logic              q_bit;

  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
    if (funct3[2]) begin
      sign_a = ~funct3[0] & op_a[XLEN-1];
      sign_b = ~funct3[0] & op_b[XLEN-1];
    end else begin
      sign_a = ~(funct3[1] & funct3[0]) & op_a[XLEN-1];
      sign_b = ~funct3[1] & op_b[XLEN-1];
    end
    a_mag_in = sign_a ? -op_a : op_a;
    b_mag_in = sign_b ? -op_b : op_b;
    // remainder takes the dividend's sign; everything else takes the product/quotient sign
    neg_in = (funct3[2] & funct3[1]) ? sign_a : (sign_a ^ sign_b);
  end

`ifdef MULDIV_EARLY_OUT_EN
  always_comb begin
    early = 1'b0;
    if (funct3[2])
      early = (op_b == '0) |
              (~funct3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1));
    else
      early = (op_a == '0) | (op_b == '0);
    // a zero multiply must leave a zero accumulator; overflow divide already yields q=|a|, r=0
    acc_init = (early & ~funct3[2]) ? '0 : {{XLEN{1'b0}}, a_mag_in};
  end
`else
  assign early    = 1'b0;
  assign acc_init = {{XLEN{1'b0}}, a_mag_in};
`endif

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? b_mag : {XLEN{1'b0}})};
    mul_next = {mul_sum, acc[XLEN-1:1]};
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    q_bit    = rem_sh >= {1'b0, b_mag};
    rem_new  = q_bit ? XLEN'(rem_sh - {1'b0, b_mag}) : rem_sh[XLEN-1:0];
    div_next = {rem_new, acc[XLEN-2:0], q_bit};
  end

  always_comb begin
    prod = neg_q ? -acc : acc;
    qr   = funct3_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    fin  = '0;
    if (!funct3_q[2])
      fin = (funct3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (div_zero_q)
      fin = funct3_q[1] ? a_q : '1;
    else
      fin = neg_q ? -qr : qr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FINISH spans two cycles: register the result, then hold done for one cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = early ? FINISH : CALC;
      CALC:    if (cnt == CNT_W'(XLEN-1)) state_next = FINISH;
      FINISH:  if (done_q) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      funct3_q   <= '0;
      a_q        <= '0;
      b_mag      <= '0;
      acc        <= '0;
      neg_q      <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
      result     <= '0;
      rd_out     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          funct3_q   <= funct3;
          a_q        <= op_a;
          b_mag      <= b_mag_in;
          neg_q      <= neg_in;
          div_zero_q <= funct3[2] & (op_b == '0);
          rd_out     <= rd_in;
          cnt        <= '0;
          acc        <= acc_init;
        end
        CALC: begin
          acc <= funct3_q[2] ? div_next : mul_next;
          cnt <= cnt + 1'b1;
        end
        FINISH: begin
          if (!done_q) begin
            result <= fin;
            done_q <= 1'b1;
          end else begin
            done_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = (state != IDLE);
  assign done          = done_q;
  assign reg_write_out = done_q & (rd_out != 5'd0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard testbench for muldiv_unit; expected results come from a behavioural RV32M model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, done, reg_write_out;
  logic [31:0] result;
  logic [4:0]  rd_out;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result),
    .rd_out(rd_out), .reg_write_out(reg_write_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    int sa, sbv;
    bit ovf;
    sa  = $signed(a);
    sbv = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = '0;
    case (f)
      3'b000: begin p = 64'(longint'(sa) * longint'(sbv)); r = p[31:0]; end
      3'b001: begin p = 64'(longint'(sa) * longint'(sbv)); r = p[63:32]; end
      3'b010: begin p = 64'(longint'(sa) * longint'({32'b0, b})); r = p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'b100: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sbv);
      3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: r = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sbv);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    if (!f[2] && (a == 0 || b == 0)) return 1;
`endif
    return 33;
  endfunction

  // Drives one request, scrambles the inputs after acceptance and waits (bounded) for done.
  task automatic applyStimulus(input string tag, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd, input int inject_at,
                               output int lat);
    exp_t e;
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
    e.res = ref_model(f, a, b); e.rd = rd; e.lat = ref_latency(f, a, b); e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom); rd_in = 5'($urandom);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      start = (inject_at != 0 && lat == inject_at - 1);
      if (inject_at != 0 && lat == inject_at)
        check({tag, "_busy_after_restart"}, 32'(busy), 32'd1);
    end
    start = 1'b0;
  endtask

  task automatic checkOutput(input int lat, input bit hold_start);
    exp_t e;
    e = sb_q.pop_front();
    check({e.tag, "_latency"}, 32'(lat), 32'(e.lat));
    check({e.tag, "_result"}, result, e.res);
    check({e.tag, "_rd_out"}, 32'(rd_out), 32'(e.rd));
    check({e.tag, "_reg_write"}, 32'(reg_write_out), 32'(e.rd != 5'd0));
    if (hold_start) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({e.tag, "_done_drop"}, 32'(done), 32'd0);
    check({e.tag, "_busy_drop"}, 32'(busy), 32'd0);
    check({e.tag, "_result_hold"}, result, e.res);
  endtask

  task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd, input int inject_at,
                     input bit hold_start);
    int lat;
    applyStimulus(tag, f, a, b, rd, inject_at, lat);
    checkOutput(lat, hold_start);
  endtask

  initial begin
    bit saw_done;
    $display("[TB] reset");
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd_out", 32'(rd_out), 32'd0);
    check("rst_reg_write", 32'(reg_write_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] multiply");
    run("mul_7x-3",     3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd5, 0, 0);
    run("mulhu_ff",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 0, 0);
    run("mulh_ff",      3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 0, 0);
    run("mulhsu_ff_2",  3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8, 0, 0);
    run("mulh_big",     3'b001, 32'h8000_0000, 32'h7FFF_FFFF, 5'd9, 0, 0);
    run("mul_zero",     3'b000, 32'h1234_5678, 32'h0000_0000, 5'd10, 0, 0);

    $display("[TB] divide");
    run("div_-7_2",     3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd11, 0, 0);
    run("rem_-7_2",     3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd12, 0, 0);
    run("divu_100_7",   3'b101, 32'd100, 32'd7, 5'd13, 0, 0);
    run("remu_100_7",   3'b111, 32'd100, 32'd7, 5'd14, 0, 0);
    run("div_7_-2",     3'b100, 32'd7, 32'hFFFF_FFFE, 5'd15, 0, 0);

    $display("[TB] divide boundaries");
    run("divu_5_0",     3'b101, 32'd5, 32'd0, 5'd16, 0, 0);
    run("rem_5_0",      3'b110, 32'd5, 32'd0, 5'd17, 0, 0);
    run("div_-5_0",     3'b100, 32'hFFFF_FFFB, 32'd0, 5'd18, 0, 0);
    run("div_ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 0, 0);
    run("rem_ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 0, 0);

    $display("[TB] x0 destination, ignored starts");
    run("mul_3x4_x0",   3'b000, 32'd3, 32'd4, 5'd0, 10, 1);

    $display("[TB] reset mid-operation");
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; op_a = 32'hFFFF_FF9C; op_b = 32'd7; rd_in = 5'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_rd_out", 32'(rd_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", 32'(saw_done), 32'd0);
    run("divu_9_3",     3'b101, 32'd9, 32'd3, 5'd21, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execute unit. It sits directly downstream of the register file and consumes its two read-port operands. It produces a result, destination index and write strobe that feed the register file write port (wd3/a3/reg_write) through the writeback mux. It uses a start/busy/done handshake so the core can stall while an operation is in flight.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  reset, asynchronous, active-high.
start  input  1  request; sampled only in IDLE.
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
op_a  input  32  rs1 operand (register file rd1).
op_b  input  32  rs2 operand (register file rd2).
rd_in  input  5  destination register index.
busy  output  1  high from the accept edge until the edge at which done drops.
done  output  1  single-cycle result-valid pulse.
result  output  32  result; held stable until the next accept.
rd_out  output  5  latched rd_in.
reg_write_out  output  1  equals done AND (rd_out != 0); x0 is never written.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, result=0, rd_out=0, reg_write_out=0, counter=0, all datapath regs=0. Reset mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, CALC, FINISH.
- IDLE: if start=1 at edge E0, latch funct3, op_a, op_b and rd_in; compute operand magnitudes and result sign; counter=0; go to CALC; busy=1.
- CALC: one iteration per cycle for exactly 32 cycles (edges E1..E32). Go to FINISH when counter reaches 31.
- FINISH: apply sign correction, register result, done=1 for exactly one cycle (after edge E33). Next edge returns to IDLE, busy=0, done=0.
- Latency: start at E0 gives done high in the cycle following E33. A new start is accepted at E34 at the earliest.
- start while busy=1 is ignored. start in the same cycle that done is high is ignored; that cycle is still FINISH.
- Inputs are sampled only at the accept edge. Later changes on op_a, op_b, funct3 and rd_in do not affect the operation in flight.
- Multiply: shift-add on 32-bit magnitudes into a 64-bit product.
  - Negate the 64-bit product when the result sign is 1.
  - Signedness: MUL/MULH signed×signed; MULHSU signed×unsigned; MULHU unsigned×unsigned.
  - MUL returns the low 32 bits; the other three return the high 32 bits.
- Divide: restoring division on magnitudes.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Divide boundary cases (RISC-V defined, no trap):
  - b=0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → op_a.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
  - The boundary cases still take full latency unless the optional feature is enabled.
- Arithmetic is modulo 2^32 for results; no overflow flag.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: in IDLE, the accept edge detects three cases:
  - divisor zero;
  - signed overflow (0x80000000 / -1);
  - either multiply operand zero.
- For these cases the unit skips CALC and enters FINISH directly. done is high in the cycle following E1, with the RISC-V result values above (0 for a zero multiply operand).
- Not defined: every operation takes the fixed 33-edge latency; the detection logic is absent.

Test Plan:
- MUL 7 × -3 (0x00000007, 0xFFFFFFFD), rd_in=5, start at E0 → done in cycle after E33; result=0xFFFFFFEB; rd_out=5; reg_write_out=1 for one cycle.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULH of the same operands → 0x00000000. MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- DIV -7 / 2 → 0xFFFFFFFD; REM -7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIVU 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. Latency is 33 edges without the macro and 1 edge with it.
- rd_in=0 with MUL 3 × 4 → done=1, result=12, reg_write_out=0. A second start pulse at E10 is ignored; busy stays 1 and the result is unchanged.
- Assert reset at E15 of a DIV → busy, done, result and rd_out go to 0 immediately. No done pulse follows. A new DIVU 9 / 3 after reset release → result 3.
